// File: rtl/io_port_responder.sv
`default_nettype none
//============================================================================
// Module   : io_port_responder
// Purpose  : CPU IO-port bus responder with TX/RX FIFOs, status register,
//            four general output latches and a synchronized general input.
//            Optional TX->RX loopback is built when IO_LOOPBACK_EN is defined.
// Revision : 1.0
//============================================================================
module io_port_responder #(
    parameter int TX_DEPTH_LOG2 = 3,
    parameter int RX_DEPTH_LOG2 = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  ioAdrs,
    input  logic [15:0] ioOut,
    input  logic        ioWe,
    output logic [15:0] ioIn,
    output logic [15:0] txData,
    output logic        txValid,
    input  logic        txReady,
    input  logic [15:0] rxData,
    input  logic        rxValid,
    output logic [15:0] genOut0,
    output logic [15:0] genOut1,
    output logic [15:0] genOut2,
    output logic [15:0] genOut3,
    input  logic [15:0] genIn
);

    localparam int c_TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int c_RX_DEPTH = 1 << RX_DEPTH_LOG2;

    localparam logic [TX_DEPTH_LOG2:0]   c_TX_FULL    = (TX_DEPTH_LOG2+1)'(c_TX_DEPTH);
    localparam logic [RX_DEPTH_LOG2:0]   c_RX_FULL    = (RX_DEPTH_LOG2+1)'(c_RX_DEPTH);
    localparam logic [TX_DEPTH_LOG2:0]   c_TX_CNT_ONE = (TX_DEPTH_LOG2+1)'(1);
    localparam logic [RX_DEPTH_LOG2:0]   c_RX_CNT_ONE = (RX_DEPTH_LOG2+1)'(1);
    localparam logic [TX_DEPTH_LOG2-1:0] c_TX_PTR_ONE = TX_DEPTH_LOG2'(1);
    localparam logic [RX_DEPTH_LOG2-1:0] c_RX_PTR_ONE = RX_DEPTH_LOG2'(1);

    localparam logic [3:0] c_ADR_STATUS = 4'h0;
    localparam logic [3:0] c_ADR_RXDATA = 4'h1;
    localparam logic [3:0] c_ADR_TXDATA = 4'h2;
    localparam logic [3:0] c_ADR_GENIN  = 4'h8;

    // ------------------------------------------------------------------
    // Write strobe edge detect and address decode
    // ------------------------------------------------------------------
    logic r_we_prev;
    logic w_wr;
    logic w_dec;
    logic [3:0] w_sel;
    logic w_status_wr;
    logic w_gen_wr;

    // Resetting to 1 blocks a commit from ioWe held high through reset.
    always_ff @(posedge clk) begin
        if (reset) r_we_prev <= 1'b1;
        else       r_we_prev <= ioWe;
    end

    assign w_dec       = (ioAdrs[7:4] == 4'h0);
    assign w_sel       = ioAdrs[3:0];
    assign w_wr        = ioWe && !r_we_prev && w_dec;
    assign w_status_wr = w_wr && (w_sel == c_ADR_STATUS);
    assign w_gen_wr    = w_wr && (w_sel[3:2] == 2'b01);

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [15:0]              r_tx_mem [c_TX_DEPTH];
    logic [TX_DEPTH_LOG2-1:0] r_tx_wp;
    logic [TX_DEPTH_LOG2-1:0] r_tx_rp;
    logic [TX_DEPTH_LOG2:0]   r_tx_cnt;
    logic [TX_DEPTH_LOG2:0]   w_tx_cnt_nxt;
    logic w_tx_nempty;
    logic w_tx_full;
    logic w_tx_fire;
    logic w_tx_pop;
    logic w_tx_wr;
    logic w_tx_push;
    logic w_tx_drop;
    logic [15:0] w_tx_head;

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    logic [15:0]              r_rx_mem [c_RX_DEPTH];
    logic [RX_DEPTH_LOG2-1:0] r_rx_wp;
    logic [RX_DEPTH_LOG2-1:0] r_rx_rp;
    logic [RX_DEPTH_LOG2:0]   r_rx_cnt;
    logic [RX_DEPTH_LOG2:0]   w_rx_cnt_nxt;
    logic w_rx_nempty;
    logic w_rx_full;
    logic w_rx_pop;
    logic w_rx_push;
    logic w_rx_ovf;
    logic [15:0] w_rx_wdata;
    logic [15:0] w_rx_head;

    logic w_lb_move;
    logic w_lb_bit;

    assign w_tx_nempty = (r_tx_cnt != '0);
    assign w_tx_full   = (r_tx_cnt == c_TX_FULL);
    assign w_tx_head   = w_tx_nempty ? r_tx_mem[r_tx_rp] : 16'h0000;
    assign w_rx_nempty = (r_rx_cnt != '0);
    assign w_rx_full   = (r_rx_cnt == c_RX_FULL);
    assign w_rx_head   = w_rx_nempty ? r_rx_mem[r_rx_rp] : 16'h0000;

`ifdef IO_LOOPBACK_EN
    logic r_loopback;

    always_ff @(posedge clk) begin
        if (reset)            r_loopback <= 1'b0;
        else if (w_status_wr) r_loopback <= ioOut[3];
    end

    // An external rxValid owns the RX write port; the loopback move waits.
    assign w_lb_move = r_loopback && w_tx_nempty && !w_rx_full && !rxValid;
    assign w_tx_fire = !r_loopback && w_tx_nempty && txReady;
    assign txValid   = !r_loopback && w_tx_nempty;
    assign w_lb_bit  = r_loopback;
`else
    assign w_lb_move = 1'b0;
    assign w_tx_fire = w_tx_nempty && txReady;
    assign txValid   = w_tx_nempty;
    assign w_lb_bit  = 1'b0;
`endif

    assign txData = w_tx_head;

    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    assign w_tx_pop  = w_tx_fire || w_lb_move;
    assign w_tx_wr   = w_wr && (w_sel == c_ADR_TXDATA);
    assign w_tx_push = w_tx_wr && (!w_tx_full || w_tx_pop);
    assign w_tx_drop = w_tx_wr && w_tx_full && !w_tx_pop;

    assign w_rx_pop   = w_wr && (w_sel == c_ADR_RXDATA) && w_rx_nempty;
    assign w_rx_push  = (rxValid && (!w_rx_full || w_rx_pop)) || w_lb_move;
    assign w_rx_ovf   = rxValid && w_rx_full && !w_rx_pop;
    assign w_rx_wdata = rxValid ? rxData : w_tx_head;

    always_comb begin
        w_tx_cnt_nxt = r_tx_cnt;
        case ({w_tx_push, w_tx_pop})
            2'b10:   w_tx_cnt_nxt = r_tx_cnt + c_TX_CNT_ONE;
            2'b01:   w_tx_cnt_nxt = r_tx_cnt - c_TX_CNT_ONE;
            default: w_tx_cnt_nxt = r_tx_cnt;
        endcase
    end

    always_comb begin
        w_rx_cnt_nxt = r_rx_cnt;
        case ({w_rx_push, w_rx_pop})
            2'b10:   w_rx_cnt_nxt = r_rx_cnt + c_RX_CNT_ONE;
            2'b01:   w_rx_cnt_nxt = r_rx_cnt - c_RX_CNT_ONE;
            default: w_rx_cnt_nxt = r_rx_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + c_TX_PTR_ONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_TX_PTR_ONE;
            if (w_rx_push) r_rx_wp <= r_rx_wp + c_RX_PTR_ONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_RX_PTR_ONE;
            r_tx_cnt <= w_tx_cnt_nxt;
            r_rx_cnt <= w_rx_cnt_nxt;
        end
    end

    // Storage arrays carry no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= ioOut;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= w_rx_wdata;
    end

    // ------------------------------------------------------------------
    // Sticky flags: a set in the same cycle as a clear wins
    // ------------------------------------------------------------------
    logic r_rx_ovf;
    logic r_tx_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_ovf  <= 1'b0;
            r_tx_drop <= 1'b0;
        end else begin
            if (w_rx_ovf)                     r_rx_ovf  <= 1'b1;
            else if (w_status_wr && ioOut[2]) r_rx_ovf  <= 1'b0;
            if (w_tx_drop)                    r_tx_drop <= 1'b1;
            else if (w_status_wr && ioOut[4]) r_tx_drop <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // General outputs and synchronized general input
    // ------------------------------------------------------------------
    logic [15:0] r_gen_out [4];
    logic [15:0] r_gen_in_s1;
    logic [15:0] r_gen_in_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_gen_out[i] <= 16'h0000;
        end else if (w_gen_wr) begin
            r_gen_out[w_sel[1:0]] <= ioOut;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_gen_in_s1 <= 16'h0000;
            r_gen_in_s2 <= 16'h0000;
        end else begin
            r_gen_in_s1 <= genIn;
            r_gen_in_s2 <= r_gen_in_s1;
        end
    end

    assign genOut0 = r_gen_out[0];
    assign genOut1 = r_gen_out[1];
    assign genOut2 = r_gen_out[2];
    assign genOut3 = r_gen_out[3];

    // ------------------------------------------------------------------
    // Read path: registered, sourced from pre-update state
    // ------------------------------------------------------------------
    logic [3:0]  w_tx_cnt4;
    logic [3:0]  w_rx_cnt4;
    logic [15:0] w_status;
    logic [15:0] w_rd_data;
    logic [15:0] r_io_in;

    assign w_tx_cnt4 = 4'(r_tx_cnt);
    assign w_rx_cnt4 = 4'(r_rx_cnt);
    assign w_status  = {w_tx_cnt4, w_rx_cnt4, 3'b000, r_tx_drop, w_lb_bit,
                        r_rx_ovf, w_tx_full, w_rx_nempty};

    always_comb begin
        w_rd_data = 16'h0000;
        if (w_dec) begin
            case (w_sel)
                c_ADR_STATUS: w_rd_data = w_status;
                c_ADR_RXDATA: w_rd_data = w_rx_head;
                c_ADR_TXDATA: w_rd_data = {12'h000, w_tx_cnt4};
                4'h4, 4'h5, 4'h6, 4'h7:
                              w_rd_data = r_gen_out[w_sel[1:0]];
                c_ADR_GENIN:  w_rd_data = r_gen_in_s2;
                default:      w_rd_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_io_in <= 16'h0000;
        else       r_io_in <= w_rd_data;
    end

    assign ioIn = r_io_in;

endmodule
`default_nettype wire

// File: tb/tb_io_port_responder.sv
`default_nettype none
//============================================================================
// Module   : tb_io_port_responder
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            against a queue-based reference model of the IO responder.
// Revision : 1.0
//============================================================================
module tb_io_port_responder;

    localparam int TXD = 8;
    localparam int RXD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  ioAdrs;
    logic [15:0] ioOut;
    logic        ioWe;
    logic [15:0] ioIn;
    logic [15:0] txData;
    logic        txValid;
    logic        txReady;
    logic [15:0] rxData;
    logic        rxValid;
    logic [15:0] genOut0, genOut1, genOut2, genOut3;
    logic [15:0] genIn;

    int total = 0;
    int bad   = 0;

    io_port_responder #(.TX_DEPTH_LOG2(3), .RX_DEPTH_LOG2(3)) dut (
        .clk(clk), .reset(reset), .ioAdrs(ioAdrs), .ioOut(ioOut), .ioWe(ioWe),
        .ioIn(ioIn), .txData(txData), .txValid(txValid), .txReady(txReady),
        .rxData(rxData), .rxValid(rxValid),
        .genOut0(genOut0), .genOut1(genOut1), .genOut2(genOut2), .genOut3(genOut3),
        .genIn(genIn)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_txq[$];
    logic [15:0] m_rxq[$];
    logic [15:0] m_gen[4];
    logic [15:0] m_s1, m_s2, m_io;
    bit m_ovf, m_drop, m_lb, m_we_prev;

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_read(logic [7:0] a);
        int tn = m_txq.size();
        int rn = m_rxq.size();
        if (a[7:4] != 4'h0) return 16'h0000;
        case (a[3:0])
            4'h0: return {4'(tn), 4'(rn), 3'b000, m_drop, m_lb, m_ovf, (tn == TXD), (rn > 0)};
            4'h1: return (rn > 0) ? m_rxq[0] : 16'h0000;
            4'h2: return 16'(tn);
            4'h4, 4'h5, 4'h6, 4'h7: return m_gen[a[1:0]];
            4'h8: return m_s2;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_edge();
        logic [15:0] rd, head;
        bit wr, hit, txpop, lbmv, rxpop, set_ovf, set_drop;
        int tn, rn;
        logic [3:0] a;
        if (reset) begin
            m_txq.delete(); m_rxq.delete();
            for (int i = 0; i < 4; i++) m_gen[i] = 16'h0000;
            m_s1 = 0; m_s2 = 0; m_io = 0;
            m_ovf = 0; m_drop = 0; m_lb = 0; m_we_prev = 1;
            return;
        end
        rd    = model_read(ioAdrs);
        hit   = (ioAdrs[7:4] == 4'h0);
        a     = ioAdrs[3:0];
        wr    = ioWe && !m_we_prev && hit;
        tn    = m_txq.size();
        rn    = m_rxq.size();
        head  = 16'h0000;
        txpop = !m_lb && tn > 0 && txReady;
        lbmv  = 0;
`ifdef IO_LOOPBACK_EN
        lbmv  = m_lb && tn > 0 && rn < RXD && !rxValid;
`endif
        rxpop    = wr && a == 4'h1 && rn > 0;
        set_ovf  = 0;
        set_drop = 0;
        if (txpop || lbmv) head = m_txq.pop_front();
        if (wr && a == 4'h2) begin
            if (tn < TXD || txpop || lbmv) m_txq.push_back(ioOut);
            else set_drop = 1;
        end
        if (rxpop) void'(m_rxq.pop_front());
        if (rxValid) begin
            if (rn < RXD || rxpop) m_rxq.push_back(rxData);
            else set_ovf = 1;
        end
        if (lbmv) m_rxq.push_back(head);
        if (wr && a == 4'h0) begin
            if (ioOut[2]) m_ovf = 0;
            if (ioOut[4]) m_drop = 0;
`ifdef IO_LOOPBACK_EN
            m_lb = ioOut[3];
`endif
        end
        if (set_ovf)  m_ovf = 1;
        if (set_drop) m_drop = 1;
        if (wr && a[3:2] == 2'b01) m_gen[a[1:0]] = ioOut;
        m_s2 = m_s1;
        m_s1 = genIn;
        m_we_prev = ioWe;
        m_io = rd;
    endtask

    // One clock: advance model at the edge, compare all outputs just after it.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("ioIn", ioIn, m_io);
        check("txValid", {15'b0, txValid}, {15'b0, (!m_lb && m_txq.size() > 0)});
        check("txData", txData, (m_txq.size() > 0) ? m_txq[0] : 16'h0000);
        check("genOut0", genOut0, m_gen[0]);
        check("genOut1", genOut1, m_gen[1]);
        check("genOut2", genOut2, m_gen[2]);
        check("genOut3", genOut3, m_gen[3]);
    endtask

    task automatic wr(logic [7:0] a, logic [15:0] d);
        ioAdrs = a; ioOut = d; ioWe = 1'b1;
        step();
        ioWe = 1'b0;
        step();
    endtask

    task automatic rd(logic [7:0] a);
        ioAdrs = a;
        step();
    endtask

    task automatic random_phase(int cycles, int rdy_pct, int rxv_pct);
        for (int n = 0; n < cycles; n++) begin
            int pick = $urandom_range(0, 15);
            reset   = ($urandom_range(0, 599) == 0);
            case (pick)
                10:      ioAdrs = 8'h0F;
                11:      ioAdrs = 8'h12;
                12:      ioAdrs = 8'hF1;
                13, 14, 15: ioAdrs = 8'h02;
                default: ioAdrs = 8'(pick);
            endcase
            ioOut   = 16'($urandom);
            ioWe    = 1'($urandom_range(0, 1));
            txReady = ($urandom_range(0, 99) < rdy_pct);
            rxValid = ($urandom_range(0, 99) < rxv_pct);
            rxData  = 16'($urandom);
            genIn   = 16'($urandom);
            step();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ioAdrs = 8'h00; ioOut = 16'h0000; ioWe = 1'b0;
        txReady = 1'b0; rxData = 16'h0000; rxValid = 1'b0; genIn = 16'h0000;
        repeat (3) step();
        reset = 1'b0;

        // Reset state readback
        rd(8'h00); check("t1_status", ioIn, 16'h0000);
        rd(8'h04); check("t1_genout0", ioIn, 16'h0000);
        rd(8'h01); check("t1_rxdata", ioIn, 16'h0000);
        check("t1_txvalid", {15'b0, txValid}, 16'h0000);

        // TX push and drain
        wr(8'h02, 16'h1234);
        wr(8'h02, 16'hABCD);
        check("t2_txvalid", {15'b0, txValid}, 16'h0001);
        check("t2_txdata", txData, 16'h1234);
        rd(8'h00); check("t2_txcount", {12'h000, ioIn[15:12]}, 16'h0002);
        txReady = 1'b1;
        step(); check("t2_txdata2", txData, 16'hABCD);
        step(); check("t2_txempty", {15'b0, txValid}, 16'h0000);
        txReady = 1'b0;

        // Held ioWe commits once
        ioAdrs = 8'h05; ioOut = 16'h00FF; ioWe = 1'b1;
        repeat (5) step();
        ioWe = 1'b0; step();
        check("t3_genout1", genOut1, 16'h00FF);
        ioAdrs = 8'h02; ioOut = 16'h0777; ioWe = 1'b1;
        repeat (5) step();
        ioWe = 1'b0; step();
        rd(8'h00); check("t3_txcount", {12'h000, ioIn[15:12]}, 16'h0001);
        txReady = 1'b1; step(); txReady = 1'b0;

        // RX overflow and pop
        for (int i = 1; i <= 9; i++) begin
            rxValid = 1'b1; rxData = 16'(i);
            step();
        end
        rxValid = 1'b0;
        rd(8'h00);
        check("t4_rxcount", {12'h000, ioIn[11:8]}, 16'h0008);
        check("t4_ovf", {15'b0, ioIn[2]}, 16'h0001);
        rd(8'h01); check("t4_head", ioIn, 16'h0001);
        wr(8'h00, 16'h0004);
        rd(8'h00); check("t4_ovf_clr", {15'b0, ioIn[2]}, 16'h0000);
        wr(8'h01, 16'h0000);
        rd(8'h01); check("t4_head2", ioIn, 16'h0002);

        // Full RX: simultaneous pop and push
        rxValid = 1'b1; rxData = 16'h0099; step(); rxValid = 1'b0;
        ioAdrs = 8'h01; ioWe = 1'b1; rxValid = 1'b1; rxData = 16'h00AA;
        step();
        ioWe = 1'b0; rxValid = 1'b0; step();
        rd(8'h00);
        check("t5_rxcount", {12'h000, ioIn[11:8]}, 16'h0008);
        check("t5_noovf", {15'b0, ioIn[2]}, 16'h0000);
        repeat (7) wr(8'h01, 16'h0000);
        rd(8'h01); check("t5_last", ioIn, 16'h00AA);
        wr(8'h01, 16'h0000);

`ifdef IO_LOOPBACK_EN
        // Loopback moves TX head into RX while txValid stays low
        wr(8'h00, 16'h0008);
        ioAdrs = 8'h02; ioOut = 16'h5555; ioWe = 1'b1;
        step(); check("t6_txvalid_a", {15'b0, txValid}, 16'h0000);
        ioWe = 1'b0;
        step(); check("t6_txvalid_b", {15'b0, txValid}, 16'h0000);
        rd(8'h01); check("t6_loop", ioIn, 16'h5555);
        wr(8'h01, 16'h0000);
        wr(8'h00, 16'h0000);
`endif

        // Randomized traffic with varied pressure
        random_phase(1500, 30, 50);
        random_phase(1500, 80, 20);
        random_phase(1000, 5, 70);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
